// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite slave front end: turns each single-beat read/write into one go/done
// transaction on a simple register port, with a watchdog forcing SLVERR on a stall.
module axi_lite_slave_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                  axi_clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [31:0]           reg_wr_data,
  output logic [3:0]            reg_wr_be,
  output logic                  reg_rd_go,
  output logic                  reg_wr_go,
  input  logic [31:0]           reg_rd_data,
  input  logic                  reg_rd_done,
  input  logic                  reg_wr_done,
  input  logic                  reg_error
);

  typedef enum logic [2:0] {IDLE, WR_COLLECT, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP} state_t;

  state_t                   state;
  logic                     aw_held, w_held;
  logic [TIMEOUT_WIDTH-1:0] wdog;

  logic idle, collect, ar_fire, aw_fire, w_fire, aw_now, w_now, timeout;

  assign idle    = (state == IDLE);
  assign collect = (state == WR_COLLECT);

  // Reads win a tie in IDLE; READY is held low while reset is asserted.
  assign S_AXI_ARREADY = ~rst & idle & ~aw_held & ~w_held;
  assign S_AXI_AWREADY = ~rst & (idle | collect) & ~aw_held & ~(idle & S_AXI_ARVALID);
  assign S_AXI_WREADY  = ~rst & (idle | collect) & ~w_held  & ~(idle & S_AXI_ARVALID);

  assign ar_fire = S_AXI_ARVALID & S_AXI_ARREADY;
  assign aw_fire = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_fire  = S_AXI_WVALID  & S_AXI_WREADY;
  assign aw_now  = aw_held | aw_fire;
  assign w_now   = w_held  | w_fire;
  assign timeout = &wdog;

  always_ff @(posedge axi_clk) begin
    if (rst) begin
      state        <= IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      wdog         <= '0;
      S_AXI_BRESP  <= 2'b00;
      S_AXI_BVALID <= 1'b0;
      S_AXI_RDATA  <= 32'h0;
      S_AXI_RRESP  <= 2'b00;
      S_AXI_RVALID <= 1'b0;
      reg_addr     <= '0;
      reg_wr_data  <= 32'h0;
      reg_wr_be    <= 4'h0;
      reg_rd_go    <= 1'b0;
      reg_wr_go    <= 1'b0;
    end else begin
      reg_rd_go <= 1'b0;
      reg_wr_go <= 1'b0;
      case (state)
        IDLE, WR_COLLECT: begin
          if (ar_fire) begin
            reg_addr  <= S_AXI_ARADDR;
            reg_rd_go <= 1'b1;
            wdog      <= '0;
            state     <= RD_WAIT;
          end else begin
            if (aw_fire) begin
              reg_addr <= S_AXI_AWADDR;
              aw_held  <= 1'b1;
            end
            if (w_fire) begin
              reg_wr_data <= S_AXI_WDATA;
              reg_wr_be   <= S_AXI_WSTRB;
              w_held      <= 1'b1;
            end
            // Issue as soon as both halves are in, including the same-cycle case.
            if (aw_now && w_now) begin
              aw_held   <= 1'b0;
              w_held    <= 1'b0;
              reg_wr_go <= 1'b1;
              wdog      <= '0;
              state     <= WR_WAIT;
            end else if (aw_fire || w_fire) begin
              state <= WR_COLLECT;
            end
          end
        end
        WR_WAIT: begin
          if (reg_wr_done) begin
            S_AXI_BRESP  <= reg_error ? 2'b10 : 2'b00;
            S_AXI_BVALID <= 1'b1;
            state        <= WR_RESP;
          end else if (timeout) begin
            S_AXI_BRESP  <= 2'b10;
            S_AXI_BVALID <= 1'b1;
            state        <= WR_RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RD_WAIT: begin
          if (reg_rd_done) begin
            S_AXI_RDATA  <= reg_rd_data;
            S_AXI_RRESP  <= reg_error ? 2'b10 : 2'b00;
            S_AXI_RVALID <= 1'b1;
            state        <= RD_RESP;
          end else if (timeout) begin
            S_AXI_RDATA  <= 32'hDEAD_BEEF;
            S_AXI_RRESP  <= 2'b10;
            S_AXI_RVALID <= 1'b1;
            state        <= RD_RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        WR_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            wdog         <= '0;
            state        <= IDLE;
          end
        end
        RD_RESP: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            wdog         <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_if.sv
// Scoreboarded bench for axi_lite_slave_if: directed cases plus randomized
// transactions; a monitor checks every presented B/R beat against a queue.
module tb_axi_lite_slave_if;
  localparam int AW = 32;
  localparam int TW = 4;

  logic          axi_clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
  logic          S_AXI_AWVALID = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_ARVALID = 1'b0;
  logic          S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY;
  logic [31:0]   S_AXI_WDATA = '0;
  logic [3:0]    S_AXI_WSTRB = '0;
  logic [1:0]    S_AXI_BRESP, S_AXI_RRESP;
  logic          S_AXI_BVALID, S_AXI_RVALID;
  logic          S_AXI_BREADY = 1'b0, S_AXI_RREADY = 1'b0;
  logic [31:0]   S_AXI_RDATA;
  logic [AW-1:0] reg_addr;
  logic [31:0]   reg_wr_data;
  logic [3:0]    reg_wr_be;
  logic          reg_rd_go, reg_wr_go;
  logic [31:0]   reg_rd_data = '0;
  logic          reg_rd_done = 1'b0, reg_wr_done = 1'b0, reg_error = 1'b0;

  axi_lite_slave_if #(.ADDR_WIDTH(AW), .TIMEOUT_WIDTH(TW)) dut (
    .axi_clk(axi_clk), .rst(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_wr_be(reg_wr_be),
    .reg_rd_go(reg_rd_go), .reg_wr_go(reg_wr_go), .reg_rd_data(reg_rd_data),
    .reg_rd_done(reg_rd_done), .reg_wr_done(reg_wr_done), .reg_error(reg_error)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct packed {
    logic        is_rd;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic rdy_hold = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic flag(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event expected none/bound", nm);
  endtask

  // Response monitor: every cycle a beat is presented it must match the queue head.
  always @(negedge axi_clk) begin
    if (!rst) begin
      if (S_AXI_RVALID) begin
        if (exp_q.size() == 0 || !exp_q[0].is_rd) flag("unexpected_r");
        else begin
          chk("rdata", S_AXI_RDATA, exp_q[0].data);
          chk("rresp", {30'b0, S_AXI_RRESP}, {30'b0, exp_q[0].resp});
          if (S_AXI_RREADY) void'(exp_q.pop_front());
        end
      end
      if (S_AXI_BVALID) begin
        if (exp_q.size() == 0 || exp_q[0].is_rd) flag("unexpected_b");
        else begin
          chk("bresp", {30'b0, S_AXI_BRESP}, {30'b0, exp_q[0].resp});
          if (S_AXI_BREADY) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial forever begin
    @(posedge axi_clk); #1;
    S_AXI_RREADY = !rdy_hold && ($urandom_range(0, 2) == 0);
    S_AXI_BREADY = !rdy_hold && ($urandom_range(0, 2) == 0);
  end

  task automatic drive_ar(input logic [31:0] a);
    logic f = 1'b0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 300 && !f; i++) begin
      @(negedge axi_clk); f = S_AXI_ARREADY;
      @(posedge axi_clk); #1;
    end
    S_AXI_ARVALID = 1'b0;
    if (!f) flag("ar_handshake_timeout");
  endtask

  task automatic drive_aw(input logic [31:0] a);
    logic f = 1'b0;
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
    for (int i = 0; i < 300 && !f; i++) begin
      @(negedge axi_clk); f = S_AXI_AWREADY;
      @(posedge axi_clk); #1;
    end
    S_AXI_AWVALID = 1'b0;
    if (!f) flag("aw_handshake_timeout");
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] be);
    logic f = 1'b0;
    S_AXI_WDATA = d; S_AXI_WSTRB = be; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 300 && !f; i++) begin
      @(negedge axi_clk); f = S_AXI_WREADY;
      @(posedge axi_clk); #1;
    end
    S_AXI_WVALID = 1'b0;
    if (!f) flag("w_handshake_timeout");
  endtask

  // Register-side responder for a read; 'to' withholds done to provoke the watchdog.
  task automatic resp_rd(input logic [31:0] a, input logic [31:0] d, input int dly,
                         input logic err, input logic to, input logic spur);
    logic got = 1'b0;
    int   n = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge axi_clk); got = reg_rd_go;
    end
    if (!got) begin flag("rd_go_timeout"); return; end
    chk("rd_addr", reg_addr, a);
    if (to) begin
      for (int i = 0; i < 40 && !S_AXI_RVALID; i++) begin
        @(negedge axi_clk); n++;
      end
      vectors++;
      if (n < 15 || n > 16) begin
        miscompares++;
        $display("FAIL rd_timeout_latency: got %0d expected 15..16", n);
      end
      return;
    end
    @(posedge axi_clk); #1;
    if (spur) reg_wr_done = 1'b1;
    repeat (dly) begin @(posedge axi_clk); #1; reg_wr_done = 1'b0; end
    reg_rd_data = d; reg_error = err; reg_rd_done = 1'b1;
    @(posedge axi_clk); #1;
    reg_rd_done = 1'b0; reg_wr_done = 1'b0; reg_error = 1'b0; reg_rd_data = $urandom;
  endtask

  task automatic resp_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         input int dly, input logic err, input logic to);
    logic got = 1'b0;
    int   n = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge axi_clk); got = reg_wr_go;
    end
    if (!got) begin flag("wr_go_timeout"); return; end
    chk("wr_addr", reg_addr, a);
    chk("wr_data", reg_wr_data, d);
    chk("wr_be", {28'b0, reg_wr_be}, {28'b0, be});
    if (to) begin
      for (int i = 0; i < 40 && !S_AXI_BVALID; i++) begin
        @(negedge axi_clk); n++;
      end
      vectors++;
      if (n < 15 || n > 16) begin
        miscompares++;
        $display("FAIL wr_timeout_latency: got %0d expected 15..16", n);
      end
      return;
    end
    @(posedge axi_clk); #1;
    repeat (dly) begin @(posedge axi_clk); #1; end
    reg_error = err; reg_wr_done = 1'b1;
    @(posedge axi_clk); #1;
    reg_wr_done = 1'b0; reg_error = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge axi_clk);
    if (exp_q.size() != 0) begin flag("response_timeout"); exp_q.delete(); end
    @(posedge axi_clk); #1;
  endtask

  function automatic exp_t mk(input logic rd, input logic [31:0] d, input logic bad);
    exp_t e;
    e.is_rd = rd; e.data = d; e.resp = bad ? 2'b10 : 2'b00;
    return e;
  endfunction

  initial begin
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    chk("rst_arready", S_AXI_ARREADY, 0);
    chk("rst_awready", S_AXI_AWREADY, 0);
    chk("rst_wready", S_AXI_WREADY, 0);
    chk("rst_valids", {S_AXI_BVALID, S_AXI_RVALID, reg_rd_go, reg_wr_go}, 0);
    chk("rst_regs", reg_addr | reg_wr_data | reg_wr_be, 0);
    @(posedge axi_clk); #1; rst = 1'b0;
    @(negedge axi_clk);
    chk("idle_arready", S_AXI_ARREADY, 1);
    @(posedge axi_clk); #1;

    // Same-cycle AW/W write, done 3 cycles after go.
    exp_q.push_back(mk(1'b0, 32'h0, 1'b0));
    fork
      drive_aw(32'h10);
      drive_w(32'hA5A5_0001, 4'hF);
      resp_wr(32'h10, 32'hA5A5_0001, 4'hF, 2, 1'b0, 1'b0);
    join
    wait_idle();

    // Read with RREADY held off for several cycles after RVALID.
    rdy_hold = 1'b1;
    exp_q.push_back(mk(1'b1, 32'h1234_5678, 1'b0));
    fork
      drive_ar(32'h24);
      resp_rd(32'h24, 32'h1234_5678, 1, 1'b0, 1'b0, 1'b0);
    join
    repeat (6) @(posedge axi_clk);
    #1; rdy_hold = 1'b0;
    wait_idle();

    // W leads AW by 4 cycles.
    exp_q.push_back(mk(1'b0, 32'h0, 1'b0));
    fork
      drive_w(32'h0000_BEEF, 4'h3);
      begin repeat (4) begin @(posedge axi_clk); #1; end drive_aw(32'h18); end
      resp_wr(32'h18, 32'h0000_BEEF, 4'h3, 0, 1'b0, 1'b0);
    join
    wait_idle();

    // AR and AW/W together in IDLE: the read is served first.
    exp_q.push_back(mk(1'b1, 32'hCAFE_0030, 1'b0));
    exp_q.push_back(mk(1'b0, 32'h0, 1'b0));
    fork
      drive_ar(32'h30);
      drive_aw(32'h34);
      drive_w(32'h5555_AAAA, 4'hC);
      begin
        resp_rd(32'h30, 32'hCAFE_0030, 2, 1'b0, 1'b0, 1'b1);
        resp_wr(32'h34, 32'h5555_AAAA, 4'hC, 1, 1'b0, 1'b0);
      end
    join
    wait_idle();

    // Read timeout, then write with reg_error.
    exp_q.push_back(mk(1'b1, 32'hDEAD_BEEF, 1'b1));
    fork
      drive_ar(32'h44);
      resp_rd(32'h44, 32'h0, 0, 1'b0, 1'b1, 1'b0);
    join
    wait_idle();
    exp_q.push_back(mk(1'b0, 32'h0, 1'b1));
    fork
      drive_aw(32'h48);
      drive_w(32'h1, 4'h1);
      resp_wr(32'h48, 32'h1, 4'h1, 1, 1'b1, 1'b0);
    join
    wait_idle();

    // Reset during RD_WAIT: everything clears and a late done is ignored.
    drive_ar(32'h40);
    @(negedge axi_clk);
    chk("mid_rd_go", reg_rd_go, 1);
    @(posedge axi_clk); #1; rst = 1'b1;
    @(posedge axi_clk); #1;
    chk("mid_rst_valid", {S_AXI_RVALID, S_AXI_BVALID, reg_rd_go, reg_wr_go}, 0);
    chk("mid_rst_ready", {S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY}, 0);
    chk("mid_rst_addr", reg_addr, 0);
    chk("mid_rst_rdata", S_AXI_RDATA, 0);
    chk("mid_rst_resp", {S_AXI_RRESP, S_AXI_BRESP}, 0);
    rst = 1'b0;
    reg_rd_data = 32'h7777_7777; reg_rd_done = 1'b1;
    @(posedge axi_clk); #1; reg_rd_done = 1'b0;
    repeat (6) @(posedge axi_clk);
    @(negedge axi_clk);
    chk("post_rst_arready", S_AXI_ARREADY, 1);
    @(posedge axi_clk); #1;

    // Randomized mix of reads/writes with errors, timeouts and skewed AW/W.
    for (int t = 0; t < 40; t++) begin
      logic        rd, err, to;
      logic [31:0] a, d;
      logic [3:0]  be;
      int          dly, ad, wd;
      rd  = ($urandom_range(0, 1) == 1);
      a   = $urandom & 32'h0000_0FFC;
      d   = $urandom;
      be  = 4'($urandom_range(1, 15));
      dly = $urandom_range(0, 8);
      err = ($urandom_range(0, 3) == 0);
      to  = ($urandom_range(0, 7) == 0);
      ad  = $urandom_range(0, 3);
      wd  = $urandom_range(0, 3);
      if (rd) begin
        exp_q.push_back(mk(1'b1, to ? 32'hDEAD_BEEF : d, to | err));
        fork
          drive_ar(a);
          resp_rd(a, d, dly, err, to, err);
        join
      end else begin
        exp_q.push_back(mk(1'b0, 32'h0, to | err));
        fork
          begin repeat (ad) begin @(posedge axi_clk); #1; end drive_aw(a); end
          begin repeat (wd) begin @(posedge axi_clk); #1; end drive_w(d, be); end
          resp_wr(a, d, be, dly, err, to);
        join
      end
      wait_idle();
    end

    repeat (4) @(posedge axi_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1);
  end
endmodule
